fifo_sync: RTL and testbench



---
 rtl/fifo_sync_pkg.sv | 17 +
 rtl/fifo_sync_ram.sv | 21 ++
 rtl/fifo_sync.sv | 89 ++++++++
 tb/tb_fifo_sync.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared widths, legacy BRAM FIFO mode encodings and clog2 helper
package fifo_sync_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 9;
  typedef enum logic [1:0] {
    MODE_256X16 = 2'd0,
    MODE_512X8 = 2'd1,
    MODE_1024X4 = 2'd2,
    MODE_2048X2 = 2'd3
  } fifo_mode_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port RAM with registered read, inferred onto SB_RAM40_4K tiles
module fifo_sync_ram import fifo_sync_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= d;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock BRAM FIFO with level, almost and sticky error flags; FIFO_SYNC_FWFT_EN selects first-word-fall-through
module fifo_sync import fifo_sync_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [LW-1:0] level_n;
  logic [DATA_WIDTH-1:0] rdata;
  logic we_ok, re_ok, rd;
  assign we_ok = we & ~full;
  assign level_n = level + LW'(we_ok) - LW'(re_ok);
  fifo_sync_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk), .rst(rst), .we(we_ok), .waddr(waddr), .d(d),
    .re(rd), .raddr(raddr), .q(rdata)
  );
`ifdef FIFO_SYNC_FWFT_EN
  // RAM read register (stage 1) feeds the output register q (stage 2); level counts both
  logic v1, load;
  logic [LW-1:0] mem_cnt;
  assign re_ok = re & q_valid;
  assign empty = ~q_valid;
  assign mem_cnt = level - LW'(v1) - LW'(q_valid);
  assign load = v1 & (~q_valid | re_ok);
  assign rd = (mem_cnt != '0) & (~v1 | load);
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      q_valid <= 1'b0;
      q <= '0;
    end else begin
      v1 <= rd | (v1 & ~load);
      if (load) begin
        q <= rdata;
        q_valid <= 1'b1;
      end else if (re_ok) q_valid <= 1'b0;
    end
`else
  assign re_ok = re & ~empty;
  assign rd = re_ok;
  assign q = rdata;
  always_ff @(posedge clk)
    if (rst) begin
      q_valid <= 1'b0;
      empty <= 1'b1;
    end else begin
      q_valid <= re_ok;
      empty <= level_n == '0;
    end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      waddr <= waddr + ADDR_WIDTH'(we_ok);
      raddr <= raddr + ADDR_WIDTH'(rd);
      level <= level_n;
      full <= level_n == LW'(DEPTH);
      almost_empty <= level_n <= LW'(AE_THRESH);
      almost_full <= level_n >= LW'(AF_THRESH);
      overflow <= overflow | (we & full);
      underflow <= underflow | (re & empty);
    end
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed vector table plus full/wrap/FWFT sequences for fifo_sync (DEPTH 16)
module tb_fifo_sync;
  logic clk = 1'b0, rst = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] d = '0, q;
  logic q_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .we(we), .d(d), .re(re), .q(q), .q_valid(q_valid),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );
  typedef struct {
    logic rst, we, re;
    logic [7:0] d, q;
    logic qv, em, fu, ae, af, ov, un;
    logic [4:0] lv;
  } vec_t;
  function automatic vec_t mk(input logic r, w, rd, input logic [7:0] dd, qq,
                              input logic qv, em, fu, ae, af, ov, un, input logic [4:0] lv);
    mk = '{r, w, rd, dd, qq, qv, em, fu, ae, af, ov, un, lv};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, w, rd, input logic [7:0] dd);
    @(negedge clk);
    rst = r; we = w; re = rd; d = dd;
    @(posedge clk);
    #1;
  endtask
  vec_t tv [18];
  logic [7:0] sb [$];
  logic [7:0] e;
  initial begin
    tv[0]  = mk(1,0,0,8'h00, 8'h00,0,1,0,1,0,0,0,5'd0);
    tv[1]  = mk(0,0,1,8'h00, 8'h00,0,1,0,1,0,0,1,5'd0);
    tv[2]  = mk(1,0,0,8'h00, 8'h00,0,1,0,1,0,0,0,5'd0);
    tv[3]  = mk(0,1,0,8'h01, 8'h00,0,0,0,1,0,0,0,5'd1);
    tv[4]  = mk(0,1,0,8'h02, 8'h00,0,0,0,1,0,0,0,5'd2);
    tv[5]  = mk(0,1,0,8'h03, 8'h00,0,0,0,0,0,0,0,5'd3);
    tv[6]  = mk(0,1,0,8'h04, 8'h00,0,0,0,0,0,0,0,5'd4);
    tv[7]  = mk(0,1,0,8'h05, 8'h00,0,0,0,0,0,0,0,5'd5);
    tv[8]  = mk(0,0,1,8'h00, 8'h01,1,0,0,0,0,0,0,5'd4);
    tv[9]  = mk(0,0,0,8'h00, 8'h01,0,0,0,0,0,0,0,5'd4);
    tv[10] = mk(0,0,1,8'h00, 8'h02,1,0,0,0,0,0,0,5'd3);
    tv[11] = mk(0,1,1,8'h06, 8'h03,1,0,0,0,0,0,0,5'd3);
    tv[12] = mk(0,0,1,8'h00, 8'h04,1,0,0,1,0,0,0,5'd2);
    tv[13] = mk(0,0,1,8'h00, 8'h05,1,0,0,1,0,0,0,5'd1);
    tv[14] = mk(0,0,1,8'h00, 8'h06,1,1,0,1,0,0,0,5'd0);
    tv[15] = mk(0,0,0,8'h00, 8'h06,0,1,0,1,0,0,0,5'd0);
    tv[16] = mk(0,1,1,8'h07, 8'h06,0,0,0,1,0,0,1,5'd1);
    tv[17] = mk(0,0,1,8'h00, 8'h07,1,1,0,1,0,0,1,5'd0);
    step(1, 0, 0, 8'h00);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ae", 32'(almost_empty), 32'h1);
    chk("rst_af", 32'(almost_full), 32'h0);
`ifndef FIFO_SYNC_FWFT_EN
    for (int i = 0; i < 18; i++) begin
      step(tv[i].rst, tv[i].we, tv[i].re, tv[i].d);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(tv[i].q));
      chk($sformatf("v%0d_qv", i), 32'(q_valid), 32'(tv[i].qv));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].em));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].fu));
      chk($sformatf("v%0d_ae", i), 32'(almost_empty), 32'(tv[i].ae));
      chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(tv[i].af));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tv[i].ov));
      chk($sformatf("v%0d_udf", i), 32'(underflow), 32'(tv[i].un));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].lv));
    end
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(8'h10 + i));
      chk("fill_level", 32'(level), 32'(i + 1));
      if (i == 1) chk("ae_at2", 32'(almost_empty), 32'h1);
      if (i == 2) chk("ae_at3", 32'(almost_empty), 32'h0);
      if (i == 10) chk("af_at11", 32'(almost_full), 32'h0);
      if (i == 11) chk("af_at12", 32'(almost_full), 32'h1);
    end
    chk("full_set", 32'(full), 32'h1);
    step(0, 1, 0, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_level", 32'(level), 32'd16);
    step(0, 1, 1, 8'hDD);
    chk("fullrw_q", 32'(q), 32'h10);
    chk("fullrw_level", 32'(level), 32'd15);
    chk("fullrw_full", 32'(full), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 8'h00);
      chk("drain_q", 32'(q), 32'(8'h11 + i));
    end
    chk("drain_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) sb.push_back(8'(8'h18 + i));
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 1, 8'(8'h20 + i));
      sb.push_back(8'(8'h20 + i));
      e = sb.pop_front();
      chk("wrap_q", 32'(q), 32'(e));
      chk("wrap_level", 32'(level), 32'd8);
    end
    step(1, 0, 0, 8'h00);
    chk("rst2_q", 32'(q), 32'h0);
    chk("rst2_ovf", 32'(overflow), 32'h0);
    chk("rst2_level", 32'(level), 32'h0);
`else
    step(0, 1, 0, 8'hA5);
    chk("fw_lv1", 32'(level), 32'd1);
    chk("fw_qv_n", 32'(q_valid), 32'h0);
    step(0, 0, 0, 8'h00);
    chk("fw_qv_n1", 32'(q_valid), 32'h0);
    step(0, 0, 0, 8'h00);
    chk("fw_qv_n2", 32'(q_valid), 32'h1);
    chk("fw_q", 32'(q), 32'hA5);
    chk("fw_empty0", 32'(empty), 32'h0);
    step(0, 0, 1, 8'h00);
    chk("fw_pop_empty", 32'(empty), 32'h1);
    chk("fw_pop_level", 32'(level), 32'd0);
    chk("fw_udf", 32'(underflow), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    chk("fw_head", 32'(q), 32'h11);
    for (int i = 1; i < 3; i++) begin
      step(0, 0, 1, 8'h00);
      chk("fw_b2b_q", 32'(q), 32'(8'h11 * (i + 1)));
      chk("fw_b2b_qv", 32'(q_valid), 32'h1);
    end
    step(0, 0, 1, 8'h00);
    chk("fw_last_empty", 32'(empty), 32'h1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
